// File: rtl/imem_loader.sv
// Byte-stream instruction-memory loader: length header, little-endian payload words, core reset release.
// Optional trailing checksum byte enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_byte_valid,
    input  logic [7:0]        i_byte_data,
    output logic              o_byte_ready,
    output logic              o_imem_we,
    output logic [ADDR_W-1:0] o_imem_addr,
    output logic [31:0]       o_imem_wdata,
    output logic              o_core_rst_n,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err
);

    // One extra bit so a full 2^ADDR_W-word load never wraps the counters.
    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [16:0] MAX_N = 17'(1) << ADDR_W;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
        CSUM,
`endif
        DONE,
        ERR
    } state_t;

    state_t           state;
    logic [7:0]       len_lo;
    logic             len_phase;
    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] word_cnt;
    logic [1:0]       byte_cnt;
    logic [23:0]      shift_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]       sum_q;
`endif

    logic        xfer;
    logic [15:0] n16;
    logic        len_bad;
    logic        last_word;

    assign xfer      = i_byte_valid && o_byte_ready;
    assign n16       = {i_byte_data, len_lo};
    assign len_bad   = (n16 == 16'd0) || ({1'b0, n16} > MAX_N);
    assign last_word = (CNT_W'(word_cnt + CNT_W'(1)) == len_q);

    // Loader FSM; every flag is updated on the same edge as the state it describes.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state        <= IDLE;
            len_lo       <= '0;
            len_phase    <= 1'b0;
            len_q        <= '0;
            word_cnt     <= '0;
            byte_cnt     <= '0;
            shift_q      <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q        <= '0;
`endif
            o_byte_ready <= 1'b0;
            o_imem_we    <= 1'b0;
            o_imem_addr  <= '0;
            o_imem_wdata <= '0;
            o_core_rst_n <= 1'b0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_err        <= 1'b0;
        end else begin
            o_imem_we <= 1'b0;
            case (state)
                IDLE, DONE, ERR: begin
                    if (i_start) begin
                        state        <= LEN;
                        len_phase    <= 1'b0;
                        word_cnt     <= '0;
                        byte_cnt     <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        sum_q        <= '0;
`endif
                        o_byte_ready <= 1'b1;
                        o_busy       <= 1'b1;
                        o_done       <= 1'b0;
                        o_err        <= 1'b0;
                        o_core_rst_n <= 1'b0;
                    end
                end
                LEN: begin
                    if (xfer) begin
                        if (!len_phase) begin
                            len_lo    <= i_byte_data;
                            len_phase <= 1'b1;
                        end else if (len_bad) begin
                            state        <= ERR;
                            o_byte_ready <= 1'b0;
                            o_busy       <= 1'b0;
                            o_err        <= 1'b1;
                        end else begin
                            state <= DATA;
                            len_q <= CNT_W'(n16);
                        end
                    end
                end
                DATA: begin
                    if (word_cnt == len_q) begin
                        // Final write strobe is out this cycle; leave DATA afterwards.
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state        <= CSUM;
                        o_byte_ready <= 1'b1;
`else
                        state        <= DONE;
                        o_busy       <= 1'b0;
                        o_done       <= 1'b1;
                        o_core_rst_n <= 1'b1;
`endif
                    end else if (xfer) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        shift_q  <= {i_byte_data, shift_q[23:8]};
`ifdef IMEM_LOADER_CHECKSUM_EN
                        sum_q    <= sum_q + i_byte_data;
`endif
                        if (byte_cnt == 2'd3) begin
                            o_imem_we    <= 1'b1;
                            o_imem_addr  <= word_cnt[ADDR_W-1:0];
                            o_imem_wdata <= {i_byte_data, shift_q};
                            word_cnt     <= CNT_W'(word_cnt + CNT_W'(1));
                            if (last_word) begin
                                o_byte_ready <= 1'b0;
                            end
                        end
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                CSUM: begin
                    if (xfer) begin
                        o_byte_ready <= 1'b0;
                        o_busy       <= 1'b0;
                        if (i_byte_data == sum_q) begin
                            state        <= DONE;
                            o_done       <= 1'b1;
                            o_core_rst_n <= 1'b1;
                        end else begin
                            state <= ERR;
                            o_err <= 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
